uart_rx_deserializer: RTL and testbench

- Receive-side counterpart of the UART TX serializer. It converts the oversampled serial data-bit field of a UART frame into a parallel word.
- Data arrives LSB first. Each bit is decided by a 3-sample majority vote at mid-bit.
- The block is driven by the RX control FSM. That FSM detects the start bit and enables this block for exactly the data-bit field.
- Output is a one-cycle done pulse plus a held parallel word, which the RX FSM passes to the parity/stop checks.

---
 rtl/uart_rx_deserializer.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// UART RX deserializer: 3-sample mid-bit majority vote, LSB-first shift into a parallel word.
// Optional `UART_RX_DESER_SAMPLE_ERR_EN adds sample_err_ds (noisy-bit flag pulsed with done).
`timescale 1ns/1ps

module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  clk_ds,
    input  logic                  rst_ds,
    input  logic                  rx_in_ds,
    input  logic                  deser_en_ds,
    output logic [DATA_WIDTH-1:0] p_data_ds,
    output logic                  deser_done_ds
`ifdef UART_RX_DESER_SAMPLE_ERR_EN
    ,
    output logic                  sample_err_ds
`endif
);

    localparam int EW = $clog2(PRESCALE);
    localparam int BW = $clog2(DATA_WIDTH) + 1;

    localparam logic [EW-1:0] E_S0   = EW'(PRESCALE/2 - 1);
    localparam logic [EW-1:0] E_S1   = EW'(PRESCALE/2);
    localparam logic [EW-1:0] E_S2   = EW'(PRESCALE/2 + 1);
    localparam logic [EW-1:0] E_LAST = EW'(PRESCALE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

    // With PRESCALE == 4 the third sample lands on the decision cycle itself
    localparam bit S2_LIVE = (PRESCALE / 2 + 1) == (PRESCALE - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [EW-1:0]         edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  s0;
    logic                  s1;
    logic                  s2;

    logic cnt_clr;
    logic samp0;
    logic samp1;
    logic samp2;
    logic bit_end;
    logic word_end;
    logic s2_eff;
    logic maj;
    logic noisy;

    always_ff @(posedge clk_ds or negedge rst_ds) begin
        if (!rst_ds) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (deser_en_ds)  state_d = SHIFT;
            SHIFT:   if (!deser_en_ds) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_clr  = 1'b1;
        samp0    = 1'b0;
        samp1    = 1'b0;
        samp2    = 1'b0;
        bit_end  = 1'b0;
        word_end = 1'b0;
        unique case (state_d)
            SHIFT: begin
                cnt_clr  = 1'b0;
                samp0    = (edge_cnt == E_S0);
                samp1    = (edge_cnt == E_S1);
                samp2    = (edge_cnt == E_S2);
                bit_end  = (edge_cnt == E_LAST);
                word_end = bit_end && (bit_cnt == B_LAST);
            end
            default: ;
        endcase
    end

    assign s2_eff = S2_LIVE ? rx_in_ds : s2;
    assign maj    = (s0 & s1) | (s0 & s2_eff) | (s1 & s2_eff);
    assign noisy  = !((s0 == s1) && (s1 == s2_eff));

    always_ff @(posedge clk_ds or negedge rst_ds) begin
        if (!rst_ds) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
        end else if (cnt_clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
        end else begin
            edge_cnt <= bit_end ? '0 : edge_cnt + 1'b1;
            if (bit_end) begin
                bit_cnt <= word_end ? '0 : bit_cnt + 1'b1;
                shift_q <= {maj, shift_q[DATA_WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_ds or negedge rst_ds) begin
        if (!rst_ds) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            if (samp0) s0 <= rx_in_ds;
            if (samp1) s1 <= rx_in_ds;
            if (samp2) s2 <= rx_in_ds;
        end
    end

    always_ff @(posedge clk_ds or negedge rst_ds) begin
        if (!rst_ds) begin
            p_data_ds     <= '0;
            deser_done_ds <= 1'b0;
        end else begin
            deser_done_ds <= word_end;
            if (word_end) p_data_ds <= {maj, shift_q[DATA_WIDTH-1:1]};
        end
    end

`ifdef UART_RX_DESER_SAMPLE_ERR_EN
    logic err_acc;

    always_ff @(posedge clk_ds or negedge rst_ds) begin
        if (!rst_ds) begin
            err_acc       <= 1'b0;
            sample_err_ds <= 1'b0;
        end else begin
            sample_err_ds <= word_end && (err_acc || noisy);
            if (cnt_clr || word_end) begin
                err_acc <= 1'b0;
            end else if (bit_end && noisy) begin
                err_acc <= 1'b1;
            end
        end
    end
`else
    logic unused_noisy;
    assign unused_noisy = noisy;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: default instance plus a
// DATA_WIDTH=7 / PRESCALE=16 instance sharing the serial line.
`timescale 1ns/1ps

module tb_uart_rx_deserializer;

    logic       clk_ds = 1'b0;
    logic       rst_ds;
    logic       rx_in_ds;
    logic [1:0] en;
    logic [7:0] p0;
    logic       d0;
    logic [6:0] p1;
    logic       d1;
`ifdef UART_RX_DESER_SAMPLE_ERR_EN
    logic       e0;
    logic       e1;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses0 = 0;
    int pulses1 = 0;
    int last0 = 0;
    int prev0 = 0;
    int n;

    always #5 clk_ds = ~clk_ds;

    uart_rx_deserializer #(.DATA_WIDTH(8), .PRESCALE(8)) dut0 (
        .clk_ds        (clk_ds),
        .rst_ds        (rst_ds),
        .rx_in_ds      (rx_in_ds),
        .deser_en_ds   (en[0]),
        .p_data_ds     (p0),
        .deser_done_ds (d0)
`ifdef UART_RX_DESER_SAMPLE_ERR_EN
        ,
        .sample_err_ds (e0)
`endif
    );

    uart_rx_deserializer #(.DATA_WIDTH(7), .PRESCALE(16)) dut1 (
        .clk_ds        (clk_ds),
        .rst_ds        (rst_ds),
        .rx_in_ds      (rx_in_ds),
        .deser_en_ds   (en[1]),
        .p_data_ds     (p1),
        .deser_done_ds (d1)
`ifdef UART_RX_DESER_SAMPLE_ERR_EN
        ,
        .sample_err_ds (e1)
`endif
    );

    always @(posedge clk_ds) cyc = cyc + 1;

    always @(negedge clk_ds) begin
        if (d0) begin
            pulses0 = pulses0 + 1;
            prev0   = last0;
            last0   = cyc;
        end
        if (d1) pulses1 = pulses1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk_ds);
        #1;
    endtask

    // Drive nb bits of d LSB first, ps cycles each; optionally invert one cycle
    task automatic send_bits(input int sel, input int nb, input int ps,
                             input logic [15:0] d, input int gbit,
                             input int gcyc);
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < ps; c++) begin
                rx_in_ds = (b == gbit && c == gcyc) ? ~d[b] : d[b];
                en[sel]  = 1'b1;
                step(1);
            end
        end
    endtask

    initial begin
        rst_ds   = 1'b0;
        rx_in_ds = 1'b1;
        en       = 2'b00;
        step(2);
        check("rst_p0", p0, 0);
        check("rst_d0", d0, 0);
        check("rst_p1", p1, 0);
        check("rst_d1", d1, 0);
`ifdef UART_RX_DESER_SAMPLE_ERR_EN
        check("rst_e0", e0, 0);
`endif
        rst_ds = 1'b1;
        step(1);

        n = pulses0;
        send_bits(0, 8, 8, 16'hA5, -1, 0);
        check("a5_done", d0, 1);
        check("a5_early", pulses0, n);
        check("a5_data", p0, 8'hA5);
`ifdef UART_RX_DESER_SAMPLE_ERR_EN
        check("a5_err", e0, 0);
`endif
        en[0]    = 1'b0;
        rx_in_ds = 1'b1;
        step(1);
        check("a5_onecyc", d0, 0);
        check("a5_hold", p0, 8'hA5);

        send_bits(0, 8, 8, 16'h3C, 2, 4);
        check("glitch_done", d0, 1);
        check("glitch_data", p0, 8'h3C);
`ifdef UART_RX_DESER_SAMPLE_ERR_EN
        check("glitch_err", e0, 1);
`endif
        en[0] = 1'b0;
        step(1);

        n = pulses0;
        for (int i = 0; i < 20; i++) begin
            rx_in_ds = i[0];
            step(1);
        end
        check("ign_data", p0, 8'h3C);
        check("ign_pulses", pulses0, n);

        n = pulses0;
        send_bits(0, 8, 8, 16'hFF, -1, 0);
        check("ff_data", p0, 8'hFF);
        send_bits(0, 3, 8, 16'h00, -1, 0);
        en[0] = 1'b0;
        step(10);
        check("abort_pulses", pulses0, n + 1);
        check("abort_data", p0, 8'hFF);
        send_bits(0, 8, 8, 16'h5A, -1, 0);
        check("5a_done", d0, 1);
        check("5a_data", p0, 8'h5A);
        en[0] = 1'b0;
        step(1);

        n = pulses0;
        send_bits(0, 8, 8, 16'hC3, -1, 0);
        check("b2b_done1", d0, 1);
        check("b2b_data1", p0, 8'hC3);
        send_bits(0, 8, 8, 16'h81, -1, 0);
        check("b2b_done2", d0, 1);
        check("b2b_data2", p0, 8'h81);
        en[0] = 1'b0;
        step(1);
        check("b2b_pulses", pulses0, n + 2);
        check("b2b_space", last0 - prev0, 64);

        n = pulses0;
        send_bits(0, 5, 8, 16'h77, -1, 0);
        rx_in_ds = 1'b1;
        step(3);
        rst_ds = 1'b0;
        #1;
        check("rstmid_p0", p0, 0);
        check("rstmid_d0", d0, 0);
        en[0] = 1'b0;
        step(1);
        check("rstmid_pulses", pulses0, n);
        rst_ds = 1'b1;
        step(1);
        send_bits(0, 8, 8, 16'h77, -1, 0);
        check("77_done", d0, 1);
        check("77_data", p0, 8'h77);
        en[0] = 1'b0;
        step(1);

        check("w7_idle", p1, 0);
        n = pulses1;
        send_bits(1, 7, 16, 16'h55, -1, 0);
        check("w7_done", d1, 1);
        check("w7_early", pulses1, n);
        check("w7_data", p1, 7'h55);
        en[1] = 1'b0;
        step(1);
        check("w7_onecyc", d1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
